// File: rtl/hub75_scan_driver_if.sv
// Pixel-source and panel signal bundle for the HUB75 scan driver.
// Carries bright_i only when HUB75_DIM_EN is defined.
interface hub75_scan_driver_if #(
  parameter int COLS      = 64,
  parameter int ROWS_HALF = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS_HALF);

  logic          en;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          r0_i, g0_i, b0_i;
  logic          r1_i, g1_i, b1_i;
  logic          r0_o, g0_o, b0_o;
  logic          r1_o, g1_o, b1_o;
  logic          sclk_o, lat_o, oe_n_o;
  logic [RW-1:0] addr_o;
  logic          frame_o, shift_o;
`ifdef HUB75_DIM_EN
  logic [2:0]    bright_i;
`endif

  modport master (
`ifdef HUB75_DIM_EN
    input  bright_i,
`endif
    input  en,
    input  r0_i, g0_i, b0_i,
    input  r1_i, g1_i, b1_i,
    output col_o, row_o,
    output r0_o, g0_o, b0_o,
    output r1_o, g1_o, b1_o,
    output sclk_o, lat_o, oe_n_o,
    output addr_o, frame_o, shift_o
  );

  modport slave (
`ifdef HUB75_DIM_EN
    output bright_i,
`endif
    output en,
    output r0_i, g0_i, b0_i,
    output r1_i, g1_i, b1_i,
    input  col_o, row_o,
    input  r0_o, g0_o, b0_o,
    input  r1_o, g1_o, b1_o,
    input  sclk_o, lat_o, oe_n_o,
    input  addr_o, frame_o, shift_o
  );
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 panel scan controller: shift, latch, display per row pair.
// Optional HUB75_DIM_EN adds bright_i to shorten the oe_n_o window.
module hub75_scan_driver #(
  parameter int COLS            = 64,
  parameter int ROWS_HALF       = 16,
  parameter int CLK_DIV         = 2,
  parameter int ON_CYCLES       = 256,
  parameter int FRAMES_PER_TICK = 30
) (
  input logic          clk,
  input logic          rst,
  hub75_scan_driver_if.master bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS_HALF);
  localparam int PW = $clog2(2*CLK_DIV);
  localparam int DW = $clog2(ON_CYCLES);
  localparam int FW = $clog2(FRAMES_PER_TICK+1);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_HALF-1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*CLK_DIV-1);
  localparam logic [PW-1:0] PH_HI    = PW'(CLK_DIV);
  localparam logic [DW-1:0] CNT_LAST = DW'(ON_CYCLES-1);
  localparam logic [FW-1:0] F_LAST   = FW'(FRAMES_PER_TICK-1);

  typedef enum logic [1:0] {
    IDLE, SHIFT, LATCH, DISPLAY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [5:0]    rgb_q, rgb_d;
  logic [RW-1:0] addr_q, addr_d;
  logic          sclk_q, sclk_d;
  logic          lat_q, lat_d;
  logic          oe_n_q, oe_n_d;
  logic          frame_q, frame_d;
  logic          shift_q, shift_d;
  logic [5:0]    pix;
`ifdef HUB75_DIM_EN
  logic [2:0]    bright_q, bright_d;
  logic [DW:0]   on_lim;
`endif

  assign pix = {bus.r0_i, bus.g0_i, bus.b0_i,
                bus.r1_i, bus.g1_i, bus.b1_i};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    rgb_d   = rgb_q;
    addr_d  = addr_q;
    frame_d = 1'b0;
    shift_d = 1'b0;
`ifdef HUB75_DIM_EN
    bright_d = bright_q;
    on_lim   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = SHIFT;
          col_d   = '0;
          row_d   = '0;
          ph_d    = '0;
        end
      end
      SHIFT: begin
        if (ph_q == '0) rgb_d = pix;
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = LATCH;
            addr_d  = row_q;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
`ifdef HUB75_DIM_EN
        bright_d = bus.bright_i;
`endif
      end
      DISPLAY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            frame_d = 1'b1;
            if (fcnt_q == F_LAST) begin
              fcnt_d  = '0;
              shift_d = 1'b1;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
          col_d   = '0;
          ph_d    = '0;
          state_d = bus.en ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are derived from next state so every output is a flop.
    sclk_d = (state_d == SHIFT) && (ph_d >= PH_HI);
    lat_d  = (state_d == LATCH);
`ifdef HUB75_DIM_EN
    on_lim = (DW+1)'(((32'(bright_d) + 32'd1) * 32'(ON_CYCLES)) >> 3);
    oe_n_d = (state_d != DISPLAY) || ({1'b0, cnt_d} >= on_lim);
`else
    oe_n_d = (state_d != DISPLAY);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      rgb_q   <= '0;
      addr_q  <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      frame_q <= 1'b0;
      shift_q <= 1'b0;
`ifdef HUB75_DIM_EN
      bright_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      rgb_q   <= rgb_d;
      addr_q  <= addr_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      frame_q <= frame_d;
      shift_q <= shift_d;
`ifdef HUB75_DIM_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign bus.col_o   = col_q;
  assign bus.row_o   = row_q;
  assign {bus.r0_o, bus.g0_o, bus.b0_o,
          bus.r1_o, bus.g1_o, bus.b1_o} = rgb_q;
  assign bus.sclk_o  = sclk_q;
  assign bus.lat_o   = lat_q;
  assign bus.oe_n_o  = oe_n_q;
  assign bus.addr_o  = addr_q;
  assign bus.frame_o = frame_q;
  assign bus.shift_o = shift_q;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with a 4x2 panel.
// Pixel model: r0 = column parity, b1 = row parity.
module tb_hub75_scan_driver;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  hub75_scan_driver_if #(.COLS(4), .ROWS_HALF(2)) bus ();

  hub75_scan_driver #(
    .COLS(4), .ROWS_HALF(2), .CLK_DIV(2),
    .ON_CYCLES(8), .FRAMES_PER_TICK(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.r0_i = bus.col_o[0];
  assign bus.g0_i = 1'b0;
  assign bus.b0_i = 1'b0;
  assign bus.r1_i = 1'b0;
  assign bus.g1_i = 1'b0;
  assign bus.b1_i = bus.row_o[0];

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.oe_n_o !== 1'b1 || bus.lat_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold oe_n=%b lat=%b exp 1/0",
               bus.oe_n_o, bus.lat_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.sclk_o, bus.lat_o, bus.frame_o, bus.shift_o,
           bus.oe_n_o, bus.addr_o, bus.col_o} !== 8'b00001_0_00) begin
        errors++;
        $display("FAIL idle k=%0d sclk=%b lat=%b frm=%b sh=%b oe_n=%b addr=%b col=%b exp 0,0,0,0,1,0,0",
                 k, bus.sclk_o, bus.lat_o, bus.frame_o, bus.shift_o,
                 bus.oe_n_o, bus.addr_o, bus.col_o);
      end
    end
  endtask

  task automatic test_shift_latch();
    int   rises = 0;
    int   lat_n = 0;
    int   lat_at = -1;
    int   oe_lo = 0;
    int   oe_first = -1;
    logic prev = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.sclk_o && !prev) rises++;
      prev = bus.sclk_o;
      if (bus.lat_o) begin
        lat_n++;
        lat_at = k;
      end
      if (!bus.oe_n_o) begin
        oe_lo++;
        if (oe_first < 0) oe_first = k;
      end
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL sclk_rises got=%0d exp=4", rises);
    end
    checks++;
    if (lat_n != 1 || lat_at != 16) begin
      errors++;
      $display("FAIL lat_pos n=%0d at=%0d exp 1 at 16", lat_n, lat_at);
    end
    checks++;
    if (oe_lo != 8 || oe_first != 17) begin
      errors++;
      $display("FAIL oe_window n=%0d first=%0d exp 8 from 17",
               oe_lo, oe_first);
    end
    checks++;
    if (bus.addr_o !== 1'b0) begin
      errors++;
      $display("FAIL addr_row0 got=%b exp=0", bus.addr_o);
    end
  endtask

  task automatic test_data_setup();
    int   rises = 0;
    int   row;
    logic prev = bus.sclk_o;
    logic pr0 = bus.r0_o;
    logic pb1 = bus.b1_o;
    for (int j = 0; j < 50; j++) begin
      row = (j < 25) ? 1 : 0;
      if (j == 0 || j == 25) rises = 0;
      @(negedge clk);
      if (bus.sclk_o && !prev) begin
        checks++;
        if (bus.r0_o !== logic'(rises % 2)) begin
          errors++;
          $display("FAIL r0_parity j=%0d got=%b exp=%0d",
                   j, bus.r0_o, rises % 2);
        end
        checks++;
        if (bus.b1_o !== logic'(row)) begin
          errors++;
          $display("FAIL b1_row j=%0d got=%b exp=%0d", j, bus.b1_o, row);
        end
        checks++;
        if (bus.r0_o !== pr0 || bus.b1_o !== pb1) begin
          errors++;
          $display("FAIL data_stable j=%0d r0=%b b1=%b exp %b %b",
                   j, bus.r0_o, bus.b1_o, pr0, pb1);
        end
        rises++;
      end
      prev = bus.sclk_o;
      pr0 = bus.r0_o;
      pb1 = bus.b1_o;
      if (j == 17 || j == 42) begin
        checks++;
        if (bus.addr_o !== logic'(row)) begin
          errors++;
          $display("FAIL addr_latch j=%0d got=%b exp=%0d",
                   j, bus.addr_o, row);
        end
      end
      if (j == 25) begin
        checks++;
        if (bus.frame_o !== 1'b1) begin
          errors++;
          $display("FAIL frame_first got=%b exp=1", bus.frame_o);
        end
      end
    end
  endtask

  task automatic test_frame_tick();
    int   frames = 0;
    logic ef, es;
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      ef = (k > 0) && (k % 50 == 0);
      es = (k == 150) || (k == 300);
      if (bus.frame_o) frames++;
      checks++;
      if (bus.frame_o !== ef || bus.shift_o !== es) begin
        errors++;
        $display("FAIL frame_tick k=%0d frm=%b sh=%b exp %b %b",
                 k, bus.frame_o, bus.shift_o, ef, es);
      end
      if (k % 25 == 17) begin
        checks++;
        if (bus.addr_o !== logic'((k / 25) % 2)) begin
          errors++;
          $display("FAIL addr_alt k=%0d got=%b exp=%0d",
                   k, bus.addr_o, (k / 25) % 2);
        end
      end
    end
    checks++;
    if (frames != 6) begin
      errors++;
      $display("FAIL frame_count got=%0d exp=6", frames);
    end
  endtask

  task automatic test_en_drop();
    logic el, eo;
    rst = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 5) bus.en = 1'b0;
      el = (k == 16);
      eo = !(k >= 17 && k <= 24);
      checks++;
      if (bus.lat_o !== el || bus.oe_n_o !== eo) begin
        errors++;
        $display("FAIL en_drop k=%0d lat=%b oe_n=%b exp %b %b",
                 k, bus.lat_o, bus.oe_n_o, el, eo);
      end
      if (k >= 25) begin
        checks++;
        if (bus.sclk_o !== 1'b0 || bus.frame_o !== 1'b0 ||
            bus.row_o !== 1'b1) begin
          errors++;
          $display("FAIL en_idle k=%0d sclk=%b frm=%b row=%b exp 0 0 1",
                   k, bus.sclk_o, bus.frame_o, bus.row_o);
        end
      end
    end
    bus.en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.row_o !== 1'b0 || bus.col_o !== 2'd0) begin
      errors++;
      $display("FAIL restart_row0 row=%b col=%b exp 0 0",
               bus.row_o, bus.col_o);
    end
  endtask

  task automatic test_rst_mid();
    repeat (20) @(negedge clk);
    checks++;
    if (bus.oe_n_o !== 1'b0) begin
      errors++;
      $display("FAIL pre_rst_display oe_n=%b exp=0", bus.oe_n_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.oe_n_o !== 1'b1 || bus.lat_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_display oe_n=%b lat=%b exp 1 0",
               bus.oe_n_o, bus.lat_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) @(negedge clk);
    checks++;
    if (bus.lat_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_latch lat=%b exp=1", bus.lat_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.lat_o !== 1'b0 || bus.oe_n_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_latch lat=%b oe_n=%b exp 0 1",
               bus.lat_o, bus.oe_n_o);
    end
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b0;
  endtask

`ifdef HUB75_DIM_EN
  task automatic test_dim();
    logic el, eo;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.bright_i = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      el = (k == 16) || (k == 41);
      eo = !(k == 17 || k == 18 || k == 42 || k == 43);
      checks++;
      if (bus.lat_o !== el || bus.oe_n_o !== eo) begin
        errors++;
        $display("FAIL dim k=%0d lat=%b oe_n=%b exp %b %b",
                 k, bus.lat_o, bus.oe_n_o, el, eo);
      end
    end
    bus.en = 1'b0;
    bus.bright_i = 3'd7;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
`ifdef HUB75_DIM_EN
    bus.bright_i = 3'd7;
`endif
    test_reset();
    test_shift_latch();
    test_data_setup();
    test_frame_tick();
    test_en_drop();
    test_rst_mid();
`ifdef HUB75_DIM_EN
    test_dim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
